dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive denied vid cycles before vid is forced a grant (legal range 1..15).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous reset, active-high.
REQ-007 SHALL have port cpu_req  input  1  processor data-memory access this cycle.
REQ-008 SHALL have port cpu_wren  input  1  processor access is a write, qualified by cpu_req.
REQ-009 SHALL have port cpu_addr  input  ADDR_W  processor word address.
REQ-010 SHALL have port cpu_data  input  DATA_W  processor write data.
REQ-011 SHALL have port cpu_stall  output  1  processor must hold its access and PC this cycle.
REQ-012 SHALL have port cpu_q  output  DATA_W  processor read data.
REQ-013 SHALL have port vid_req  input  1  note/display engine read request, held until granted.
REQ-014 SHALL have port vid_addr  input  ADDR_W  engine read address, stable while vid_req is high.
REQ-015 SHALL have port vid_gnt  output  1  engine request accepted this cycle.
REQ-016 SHALL have port vid_valid  output  1  vid_q holds the granted read data, one-cycle pulse.
REQ-017 SHALL have port vid_q  output  DATA_W  engine read data.
REQ-018 SHALL have ports ram_wEn/ram_addr/ram_dataIn  output  1/ADDR_W/DATA_W  to the RAM; ram_dataOut  input  DATA_W  from the RAM.
REQ-019 SHALL have port conflict_cnt  output  16  count of cycles in which both requesters were active.

Function
REQ-020 SHALL grant at most one requester per cycle; a granted access drives ram_addr/ram_wEn/ram_dataIn combinationally in that cycle.
REQ-021 SHALL grant cpu when cpu_req=1 and starve_cnt<STARVE_MAX; otherwise grant vid if vid_req=1; otherwise leave the RAM idle (ram_wEn=0).
REQ-022 SHALL assert cpu_stall=1 exactly when cpu_req=1 and the vid grant is forced (starve_cnt==STARVE_MAX and vid_req=1); cpu_stall=0 in all other cycles.
REQ-023 SHALL increment starve_cnt (4-bit) on every cycle in which vid_req=1 and vid is not granted, clear it on a vid grant, and clear it when vid_req=0.
REQ-024 SHALL drive ram_wEn=1 only for a granted cpu write; a vid grant never writes.
REQ-025 SHALL maintain registered read-owner state {IDLE, CPU, VID}: next = CPU on a cpu read grant, VID on a vid grant, IDLE otherwise (including cpu write grants).
REQ-026 SHALL, in state VID, pulse vid_valid=1 and register ram_dataOut into vid_q; vid_q holds its value until the next VID return.
REQ-027 SHALL route ram_dataOut to cpu_q combinationally at all times (RAM has one-cycle synchronous read latency, matching the processor's memory stage).
REQ-028 SHALL, on back-to-back vid grants, return one vid_valid per grant in grant order with no bubble.
REQ-029 SHALL saturate conflict_cnt at 16'hFFFF.

Reset
REQ-030 SHALL, while reset=1, force state=IDLE, starve_cnt=0, vid_q=0, vid_valid=0, conflict_cnt=0, vid_gnt=0, cpu_stall=0, ram_wEn=0.
REQ-031 SHALL, on reset asserted mid-transaction, discard the outstanding read with no vid_valid pulse after reset release.

Configuration
REQ-032 SHALL implement conflict_cnt only when macro DMEM_ARB_STATS_EN is defined; without it conflict_cnt SHALL be tied to 0 and no counter register SHALL exist.

Verification
REQ-033 SHALL cover: cpu write addr 5 data 0xA5 alone, then cpu read addr 5 -> ram_wEn=1 in cycle 1, cpu_q=0xA5 the following cycle, cpu_stall=0 throughout.
REQ-034 SHALL cover: vid_req addr 7 (RAM[7]=0x1234), cpu idle -> vid_gnt same cycle, vid_valid=1 and vid_q=0x1234 next cycle.
REQ-035 SHALL cover: STARVE_MAX=4, cpu_req and vid_req held high -> cpu granted 4 cycles, cycle 5 vid_gnt=1 and cpu_stall=1, starve_cnt back to 0.
REQ-036 SHALL cover: vid_req high 3 cycles with different addresses, cpu idle -> 3 vid_valid pulses on consecutive cycles with matching data.
REQ-037 SHALL cover: reset asserted the cycle after a vid grant -> vid_valid stays 0, all outputs at reset values, conflict_cnt=0.
REQ-038 SHALL cover: with DMEM_ARB_STATS_EN, 10 conflict cycles -> conflict_cnt=10; without the macro -> conflict_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: processor port with starvation-bounded priority over a note/display read engine.
// Optional conflict statistics counter enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_q,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_q,
   output logic              ram_wEn,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dataIn,
   input  logic [DATA_W-1:0] ram_dataOut,
   output logic [15:0]       conflict_cnt
);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } owner_t;

   localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

   owner_t            owner_r;
   logic [3:0]        starve_cnt_r;
   logic              vid_valid_r;
   logic [DATA_W-1:0] vid_hold_r;
   logic              force_vid_s;
   logic              cpu_gnt_s;
   logic              vid_gnt_s;

   // Grant decision; >= guards against a count above the limit ever locking out both sides
   always_comb begin
      force_vid_s = 1'b0;
      cpu_gnt_s   = 1'b0;
      vid_gnt_s   = 1'b0;
      if (reset) begin
         force_vid_s = 1'b0;
         cpu_gnt_s   = 1'b0;
         vid_gnt_s   = 1'b0;
      end else begin
         force_vid_s = vid_req && (starve_cnt_r >= STARVE_MAX_C);
         cpu_gnt_s   = cpu_req && !force_vid_s;
         vid_gnt_s   = vid_req && !cpu_gnt_s;
      end
   end

   // RAM port multiplexer: only a granted processor write may assert the write enable
   always_comb begin
      ram_wEn    = 1'b0;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_data;
      if (cpu_gnt_s) begin
         ram_wEn = cpu_wren;
      end else if (vid_gnt_s) begin
         ram_addr = vid_addr;
      end else begin
         ram_wEn = 1'b0;
      end
   end

   // Starvation counter: counts denied engine cycles, cleared on grant or request withdrawal
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
      end else if (!vid_req || vid_gnt_s) begin
         starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != 4'hF) begin
         starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Read-owner FSM: tracks who owns the RAM data returning this cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner_r     <= OWN_IDLE;
         vid_valid_r <= 1'b0;
         vid_hold_r  <= '0;
      end else begin
         case (owner_r)
            OWN_VID: vid_hold_r <= ram_dataOut;
            default: vid_hold_r <= vid_hold_r;
         endcase
         if (cpu_gnt_s && !cpu_wren) begin
            owner_r <= OWN_CPU;
         end else if (vid_gnt_s) begin
            owner_r <= OWN_VID;
         end else begin
            owner_r <= OWN_IDLE;
         end
         vid_valid_r <= vid_gnt_s;
      end
   end

   assign cpu_stall = cpu_req && force_vid_s;
   assign vid_gnt   = vid_gnt_s;
   assign cpu_q     = ram_dataOut;
   assign vid_valid = vid_valid_r;
   // RAM data is already registered inside the RAM, so the return cycle passes it straight through
   assign vid_q     = vid_valid_r ? ram_dataOut : vid_hold_r;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] conflict_cnt_r;

   // Saturating count of cycles with both requesters active
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         conflict_cnt_r <= 16'd0;
      end else if (cpu_req && vid_req && (conflict_cnt_r != 16'hFFFF)) begin
         conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end else begin
         conflict_cnt_r <= conflict_cnt_r;
      end
   end

   assign conflict_cnt = conflict_cnt_r;
`else
   assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle synchronous RAM model.
// Expected conflict count depends on DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

   logic        clock;
   logic        reset;
   logic        cpu_req;
   logic        cpu_wren;
   logic [11:0] cpu_addr;
   logic [31:0] cpu_data;
   logic        cpu_stall;
   logic [31:0] cpu_q;
   logic        vid_req;
   logic [11:0] vid_addr;
   logic        vid_gnt;
   logic        vid_valid;
   logic [31:0] vid_q;
   logic        ram_wEn;
   logic [11:0] ram_addr;
   logic [31:0] ram_dataIn;
   logic [31:0] ram_dataOut;
   logic [15:0] conflict_cnt;

   logic [31:0] mem [0:4095];

   int checks = 0;
   int errors = 0;

`ifdef DMEM_ARB_STATS_EN
   localparam logic [31:0] EXP_CONFLICTS = 32'd10;
`else
   localparam logic [31:0] EXP_CONFLICTS = 32'd0;
`endif

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .cpu_req      (cpu_req),
      .cpu_wren     (cpu_wren),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data),
      .cpu_stall    (cpu_stall),
      .cpu_q        (cpu_q),
      .vid_req      (vid_req),
      .vid_addr     (vid_addr),
      .vid_gnt      (vid_gnt),
      .vid_valid    (vid_valid),
      .vid_q        (vid_q),
      .ram_wEn      (ram_wEn),
      .ram_addr     (ram_addr),
      .ram_dataIn   (ram_dataIn),
      .ram_dataOut  (ram_dataOut),
      .conflict_cnt (conflict_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous RAM model, preloaded during reset
   always @(posedge clock) begin
      if (reset) begin
         mem[7]      <= 32'h0000_1234;
         mem[8]      <= 32'hCAFE_0008;
         mem[9]      <= 32'hBEEF_0009;
         mem[10]     <= 32'h5A5A_000A;
         ram_dataOut <= 32'd0;
      end else begin
         if (ram_wEn) mem[ram_addr] <= ram_dataIn;
         ram_dataOut <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'd0; cpu_data = 32'd0;
      vid_req = 1'b1; vid_addr = 12'd0;
      repeat (3) @(posedge clock);
      @(negedge clock); #1;
      chk("rst_vid_gnt",   32'(vid_gnt),      32'd0);
      chk("rst_cpu_stall", 32'(cpu_stall),    32'd0);
      chk("rst_ram_wen",   32'(ram_wEn),      32'd0);
      chk("rst_vid_valid", 32'(vid_valid),    32'd0);
      chk("rst_vid_q",     vid_q,             32'd0);
      chk("rst_conflict",  32'(conflict_cnt), 32'd0);
      @(negedge clock);
      reset = 1'b0; cpu_req = 1'b0; cpu_wren = 1'b0; vid_req = 1'b0;

      // processor write then read of address 5
      @(negedge clock); cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'd5; cpu_data = 32'h0000_00A5; #1;
      chk("wr_wen",   32'(ram_wEn),   32'd1);
      chk("wr_addr",  32'(ram_addr),  32'd5);
      chk("wr_data",  ram_dataIn,     32'h0000_00A5);
      chk("wr_stall", 32'(cpu_stall), 32'd0);
      @(negedge clock); cpu_wren = 1'b0; #1;
      chk("rd_wen",   32'(ram_wEn),   32'd0);
      chk("rd_stall", 32'(cpu_stall), 32'd0);
      @(negedge clock); cpu_req = 1'b0; #1;
      chk("rd_cpu_q", cpu_q,          32'h0000_00A5);
      chk("rd_no_vv", 32'(vid_valid), 32'd0);

      // single engine read of address 7
      @(negedge clock); vid_req = 1'b1; vid_addr = 12'd7; #1;
      chk("v1_gnt",  32'(vid_gnt),  32'd1);
      chk("v1_addr", 32'(ram_addr), 32'd7);
      chk("v1_wen",  32'(ram_wEn),  32'd0);
      @(negedge clock); vid_req = 1'b0; #1;
      chk("v1_valid", 32'(vid_valid), 32'd1);
      chk("v1_q",     vid_q,          32'h0000_1234);
      chk("v1_gnt0",  32'(vid_gnt),   32'd0);
      @(negedge clock); #1;
      chk("v1_valid0", 32'(vid_valid), 32'd0);
      chk("v1_qhold",  vid_q,          32'h0000_1234);

      // starvation: cpu wins 4 cycles, then the engine is forced through
      @(negedge clock); cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'd0; vid_req = 1'b1; vid_addr = 12'd8;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("st_cpu_gnt_vid", 32'(vid_gnt),   32'd0);
         chk("st_cpu_stall",   32'(cpu_stall), 32'd0);
         @(negedge clock);
      end
      #1;
      chk("st_force_gnt",   32'(vid_gnt),   32'd1);
      chk("st_force_stall", 32'(cpu_stall), 32'd1);
      chk("st_force_addr",  32'(ram_addr),  32'd8);
      @(negedge clock); vid_addr = 12'd9; #1;
      chk("st_valid",     32'(vid_valid), 32'd1);
      chk("st_q",         vid_q,          32'hCAFE_0008);
      chk("st_reset_gnt", 32'(vid_gnt),   32'd0);
      chk("st_reset_stl", 32'(cpu_stall), 32'd0);
      @(negedge clock); cpu_req = 1'b0; #1;
      chk("st2_gnt",  32'(vid_gnt),  32'd1);
      chk("st2_addr", 32'(ram_addr), 32'd9);
      @(negedge clock); vid_req = 1'b0; #1;
      chk("st2_valid", 32'(vid_valid), 32'd1);
      chk("st2_q",     vid_q,          32'hBEEF_0009);

      // back-to-back engine reads of 8, 9, 10
      @(negedge clock); vid_req = 1'b1; vid_addr = 12'd8; #1;
      chk("bb_gnt0", 32'(vid_gnt), 32'd1);
      @(negedge clock); vid_addr = 12'd9; #1;
      chk("bb_valid0", 32'(vid_valid), 32'd1);
      chk("bb_q0",     vid_q,          32'hCAFE_0008);
      chk("bb_gnt1",   32'(vid_gnt),   32'd1);
      @(negedge clock); vid_addr = 12'd10; #1;
      chk("bb_valid1", 32'(vid_valid), 32'd1);
      chk("bb_q1",     vid_q,          32'hBEEF_0009);
      @(negedge clock); vid_req = 1'b0; #1;
      chk("bb_valid2", 32'(vid_valid), 32'd1);
      chk("bb_q2",     vid_q,          32'h5A5A_000A);
      @(negedge clock); #1;
      chk("bb_end", 32'(vid_valid), 32'd0);

      // four more conflict cycles, then the forced grant with cpu idle
      @(negedge clock); cpu_req = 1'b1; vid_req = 1'b1; vid_addr = 12'd7;
      repeat (4) @(negedge clock);
      cpu_req = 1'b0; #1;
      chk("cf_gnt",   32'(vid_gnt),   32'd1);
      chk("cf_stall", 32'(cpu_stall), 32'd0);
      @(negedge clock); vid_req = 1'b0; #1;
      chk("cf_count", 32'(conflict_cnt), EXP_CONFLICTS);
      chk("cf_q",     vid_q,             32'h0000_1234);

      // reset right after an engine grant discards the pending return
      @(negedge clock); vid_req = 1'b1; vid_addr = 12'd8; #1;
      chk("mr_gnt", 32'(vid_gnt), 32'd1);
      @(posedge clock); #1;
      reset = 1'b1; cpu_req = 1'b1; cpu_wren = 1'b1; #1;
      chk("mr_valid",    32'(vid_valid),    32'd0);
      chk("mr_q",        vid_q,             32'd0);
      chk("mr_conflict", 32'(conflict_cnt), 32'd0);
      chk("mr_gnt0",     32'(vid_gnt),      32'd0);
      chk("mr_stall",    32'(cpu_stall),    32'd0);
      chk("mr_wen",      32'(ram_wEn),      32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0; cpu_req = 1'b0; cpu_wren = 1'b0; vid_req = 1'b0; #1;
      chk("mr_post0", 32'(vid_valid), 32'd0);
      @(negedge clock); #1;
      chk("mr_post1", 32'(vid_valid), 32'd0);
      chk("mr_post_q", vid_q,         32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
